// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core and its BCD digit counters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int BCD_W            = 4;
    localparam int NUM_DIGITS       = 4;
    localparam int TICK_DIV_DEFAULT = 1000000;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// Single mod-10 BCD digit; carry is combinational so a chain of digits rolls over on one edge.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             clk100_i,
    input  logic             rstn_i,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    assign carry = en && (digit == BCD_W'(9));

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (en) begin
            digit <= carry ? '0 : digit + BCD_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch counting 00.00..99.99 s in BCD, with run/pause/clear control.
// state | meaning
// IDLE  | count zero, stopped, waiting for start_stop_i
// RUN   | prescaler advancing, digits step on each terminal count
// PAUSE | count held, stopped; clear_i returns to IDLE
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                        clk100_i,
    input  logic                        rstn_i,
    input  logic                        start_stop_i,
    input  logic                        clear_i,
    output logic [NUM_DIGITS*BCD_W-1:0] digits_o,
    output logic                        running_o,
    output logic                        tick_o
);

    localparam int                 PRESC_W  = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICK_DIV - 1);

    sw_state_t           state;
    sw_state_t           state_nxt;
    logic [PRESC_W-1:0]  presc;
    logic                run_tc;
    logic                clr_cnt;
    logic [NUM_DIGITS:0] en_chain;
    logic                wrap_unused;

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear_i is checked first in PAUSE so it wins over a simultaneous start_stop_i
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_stop_i) state_nxt = RUN;
            RUN:     if (start_stop_i) state_nxt = PAUSE;
            PAUSE: begin
                if (clear_i)           state_nxt = IDLE;
                else if (start_stop_i) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running_o = (state == RUN);
        clr_cnt   = (state == PAUSE) && clear_i;
        run_tc    = (state == RUN) && (presc == PRESC_TC);
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc <= '0;
        end else if (clr_cnt) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= run_tc ? '0 : presc + PRESC_W'(1);
        end
    end

    // Terminal count is judged on the current state, so a stop pulse on that edge still ticks
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tick_o <= 1'b0;
        end else begin
            tick_o <= run_tc;
        end
    end

    assign en_chain[0] = run_tc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk100_i (clk100_i),
            .rstn_i   (rstn_i),
            .clr      (clr_cnt),
            .en       (en_chain[i]),
            .digit    (digits_o[i*BCD_W +: BCD_W]),
            .carry    (en_chain[i+1])
        );
    end

    // Top-digit carry marks the 99.99 -> 00.00 wrap; the count simply rolls over
    assign wrap_unused = en_chain[NUM_DIGITS];

endmodule
